hwpe_ctrl_context_sched: RTL
============================

# hwpe_ctrl_context_sched

Job-context scheduler for the HWPE control path. It grants the single offload lock to one requesting core at a time and enqueues committed jobs into a ring of `N_CONTEXT` parameter contexts. It sequences the engine through start/run/done, one job at a time, in commit order. It drives the context pointers and status flags that the register file consumes: `pointer_context`, `running_context`, `full_context`, `is_critical` and `true_done`.

## Interface
- `N_CONTEXT`, default 2: number of job contexts, legal range 1..4.
- `ID_WIDTH`, default 16: width of the requester source ID.
- `LOCK_TIMEOUT`, default 256: cycles an acquired lock survives without a trigger. Used only when `HWPE_CTRL_SCHED_LOCK_TIMEOUT_EN` is defined.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `clear_i`  in  1  synchronous soft clear; same effect as reset.
- `testset_i`  in  1  lock-acquire attempt by requester `src_i`.
- `trigger_i`  in  1  job commit by requester `src_i`.
- `src_i`  in  ID_WIDTH  requester ID that qualifies `testset_i` and `trigger_i`.
- `done_i`  in  1  engine finished the current job.
- `start_o`  out  1  one-cycle engine start pulse.
- `pointer_context_o`  out  LOG_CTX  context currently being written by the offloader.
- `running_context_o`  out  LOG_CTX  context the engine is executing.
- `full_context_o`  out  1  all contexts are pending.
- `is_critical_o`  out  1  the lock is held.
- `true_done_o`  out  1  one-cycle job-completion pulse.
- `busy_o`  out  1  the FSM is not IDLE or jobs are pending.
- `lock_timeout_o`  out  1  one-cycle pulse when a held lock expires.

Notes on the ports:
- `LOG_CTX` = max(1, $clog2(N_CONTEXT)).
- All outputs reset to 0.

## Operation
- **State registers:** `lock_q`, `owner_q[ID_WIDTH]`, `pending_q[0..N_CONTEXT]`, `ptr_q`, `run_q`, FSM state.
- **Lock:** when `testset_i` is high, `lock_q=0` and `pending_q<N_CONTEXT`, the scheduler sets `lock_q` and `owner_q<=src_i` on the next edge.
  - If instead `lock_q=1` or the ring is full, there is no state change. The register file reports -2 or -1 from `is_critical_o` / `full_context_o` respectively.
- **Trigger:** accepted only when `lock_q=1` and `src_i==owner_q`. On acceptance:
  - `lock_q<=0`;
  - `ptr_q<=ptr_q+1` with explicit wrap (N_CONTEXT-1 → 0);
  - `pending_q` increments.
- A trigger without the lock, or from a non-owner, is ignored.
- **FSM (engine sequencing):**
  - IDLE → START when `pending_q>0`.
  - START asserts `start_o` and always moves to RUN.
  - RUN holds until `done_i`, then moves to DONE.
  - DONE asserts `true_done_o`, advances `run_q` (with wrap), decrements `pending_q` and returns to IDLE.
- `done_i` outside RUN is ignored.
- **Simultaneous events:**
  - An accepted trigger in the same cycle as DONE leaves `pending_q` unchanged.
  - `testset_i` in the same cycle as an accepted trigger sees the pre-edge `lock_q=1` and is refused.
- `full_context_o` = (`pending_q==N_CONTEXT`); `is_critical_o` = `lock_q`. Both are taken directly from registers.
- `busy_o` = (state!=IDLE) | (`pending_q!=0`).
- **Clear / reset mid-job:** the FSM goes to IDLE and all counters and pointers return to 0. No `true_done_o` pulse is generated for the aborted job.

## Timing
- A testset at edge T gives `is_critical_o=1` from T+1.
- A trigger at T with the FSM idle gives `pending_q=1` at T+1, `start_o` high during T+1..T+2 (the START cycle), and RUN from T+2.
- `done_i` sampled at D gives `true_done_o` high for one cycle after D. The FSM is in IDLE the following cycle; the next `start_o` comes at the earliest two cycles after the DONE cycle.
- Minimum job turnaround is 4 cycles: START, RUN (1 cycle), DONE, IDLE.
- All outputs are registered or decoded from registers. There are no combinational input-to-output paths.

## Configuration
- **`HWPE_CTRL_SCHED_LOCK_TIMEOUT_EN` defined:**
  - A counter clears on lock acquire and increments every cycle while `lock_q=1`.
  - On reaching `LOCK_TIMEOUT-1`, the lock is released on the next edge and `lock_timeout_o` pulses for one cycle. `ptr_q` and `pending_q` are unchanged.
  - If a trigger is accepted in the expiry cycle, the trigger wins and `lock_timeout_o` stays low.
- **Undefined:** there is no counter. The lock is held until a valid trigger or clear. `lock_timeout_o` is tied to 0.

## Structure
- The shared package `hwpe_ctrl_package` gains:
  - the enum `ctx_sched_state_t` (IDLE, START, RUN, DONE);
  - the struct `ctx_sched_flags_t`, bundling the five flag outputs for direct connection to the register-file flags.
- The sub-module `hwpe_ctrl_sched_lock` holds `lock_q`, `owner_q` and the optional timeout counter. The FSM and ring pointers stay in the top module.

## Test plan
- **Basic job:** reset; testset src=3; trigger src=3; `done_i` 5 cycles after `start_o` → exactly one `start_o` pulse, one `true_done_o` pulse, `running_context_o` 0→1, `busy_o` low afterwards.
- **Contention:** testset src=1 then testset src=2 → `is_critical_o=1`; owner stays 1. Trigger from src=2 ignored; trigger from src=1 accepted.
- **Full ring (N_CONTEXT=2):** two committed jobs with `done_i` held low → `full_context_o=1`. A third testset is refused with `lock_q` staying 0. After one done, `full_context_o=0`.
- **Simultaneous trigger and DONE:** `pending_q` stays 1, `ptr_q` and `run_q` both advance, and the next `start_o` follows.
- **Clear mid-RUN:** `clear_i` with one job running and one pending → all outputs 0 next cycle, no `true_done_o`, and a later `done_i` is ignored.
- **Timeout (`HWPE_CTRL_SCHED_LOCK_TIMEOUT_EN`, LOCK_TIMEOUT=8):** testset with no trigger → `lock_timeout_o` pulses 8 cycles after `is_critical_o` rises and the lock is released. With the macro undefined, the lock is still held after 1000 cycles.

Source files
------------

// File: rtl/hwpe_ctrl_package.sv
// Shared HWPE control types: context-scheduler FSM states and register-file flag bundle.
package hwpe_ctrl_package;

  // Engine sequencing states of the context scheduler
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } ctx_sched_state_t;

  // Widest context index for the legal N_CONTEXT range (1..4)
  localparam int unsigned CTX_FLAG_IDX_W = 2;

  // Flags consumed by the register file, sized for the largest ring
  typedef struct packed {
    logic [CTX_FLAG_IDX_W-1:0] pointer_context;
    logic [CTX_FLAG_IDX_W-1:0] running_context;
    logic                      full_context;
    logic                      is_critical;
    logic                      true_done;
  } ctx_sched_flags_t;

  // Context index width, never narrower than one bit
  function automatic int unsigned ctx_log2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_sched_lock.sv
// Offload lock: owner tracking, trigger qualification and optional expiry.
// Optional feature macro: HWPE_CTRL_SCHED_LOCK_TIMEOUT_EN (lock expiry counter).
module hwpe_ctrl_sched_lock #(
  parameter int unsigned ID_WIDTH     = 16,
  parameter int unsigned LOCK_TIMEOUT = 256
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clear,
  input  logic                i_testset,
  input  logic                i_trigger,
  input  logic [ID_WIDTH-1:0] i_src,
  input  logic                i_full,
  output logic                o_lock,
  output logic                o_trigger_ok_c,
  output logic                o_lock_timeout
);

  logic                r_lock;
  logic [ID_WIDTH-1:0] r_owner;
  logic                w_acquire;
  logic                w_trig_ok;
  logic                w_expire;

  // Acquire only a free lock while a context slot is still available
  assign w_acquire = i_testset & ~r_lock & ~i_full;
  // Commit only from the current owner while the lock is held
  assign w_trig_ok = i_trigger & r_lock & (i_src == r_owner);

`ifdef HWPE_CTRL_SCHED_LOCK_TIMEOUT_EN
  localparam int unsigned CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  assign w_expire = r_lock & (r_cnt == CNT_W'(LOCK_TIMEOUT - 1));

  // Hold-time counter; a commit in the expiry cycle suppresses the timeout pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (i_clear) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_acquire || !r_lock) r_cnt <= '0;
      else                      r_cnt <= r_cnt + CNT_W'(1);
      r_timeout <= w_expire & ~w_trig_ok;
    end
  end

  assign o_lock_timeout = r_timeout;
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = 32'(LOCK_TIMEOUT);
  assign w_expire         = 1'b0;
  assign o_lock_timeout   = 1'b0;
`endif

  // Lock and owner registers; commit release has priority over expiry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lock  <= 1'b0;
      r_owner <= '0;
    end else if (i_clear) begin
      r_lock  <= 1'b0;
      r_owner <= '0;
    end else if (w_trig_ok) begin
      r_lock  <= 1'b0;
    end else if (w_acquire) begin
      r_lock  <= 1'b1;
      r_owner <= i_src;
    end else if (w_expire) begin
      r_lock  <= 1'b0;
    end
  end

  assign o_lock         = r_lock;
  assign o_trigger_ok_c = w_trig_ok;

endmodule

// File: rtl/hwpe_ctrl_context_sched.sv
// Job-context scheduler: offload lock, context ring and start/run/done sequencing.
// Optional feature macro: HWPE_CTRL_SCHED_LOCK_TIMEOUT_EN (lock expiry, see lock sub-module).
module hwpe_ctrl_context_sched
  import hwpe_ctrl_package::*;
#(
  parameter  int unsigned N_CONTEXT    = 2,
  parameter  int unsigned ID_WIDTH     = 16,
  parameter  int unsigned LOCK_TIMEOUT = 256,
  localparam int unsigned LOG_CTX      = ctx_log2(N_CONTEXT)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                testset_i,
  input  logic                trigger_i,
  input  logic [ID_WIDTH-1:0] src_i,
  input  logic                done_i,
  output logic                start_o,
  output logic [LOG_CTX-1:0]  pointer_context_o,
  output logic [LOG_CTX-1:0]  running_context_o,
  output logic                full_context_o,
  output logic                is_critical_o,
  output logic                true_done_o,
  output logic                busy_o,
  output logic                lock_timeout_o
);

  localparam int unsigned PEND_W = $clog2(N_CONTEXT + 1);

  ctx_sched_state_t  r_state;
  ctx_sched_state_t  w_state_nxt;
  logic [PEND_W-1:0] r_pending;
  logic [PEND_W-1:0] w_pending_nxt;
  logic [LOG_CTX-1:0] r_ptr;
  logic [LOG_CTX-1:0] w_ptr_nxt;
  logic [LOG_CTX-1:0] r_run;
  logic [LOG_CTX-1:0] w_run_nxt;
  logic              r_start;
  logic              r_true_done;
  logic              r_full;
  logic              r_busy;
  logic              w_lock;
  logic              w_trig_ok_c;
  logic              w_lock_timeout;
  logic              w_finish;
  ctx_sched_flags_t  w_flags;

  hwpe_ctrl_sched_lock #(
    .ID_WIDTH     (ID_WIDTH),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) u_lock (
    .i_clk          (clk_i),
    .i_rst_n        (rst_ni),
    .i_clear        (clear_i),
    .i_testset      (testset_i),
    .i_trigger      (trigger_i),
    .i_src          (src_i),
    .i_full         (r_full),
    .o_lock         (w_lock),
    .o_trigger_ok_c (w_trig_ok_c),
    .o_lock_timeout (w_lock_timeout)
  );

  assign w_finish = (r_state == DONE);

  // Next ring pointers, pending count and engine state
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_ptr_nxt     = r_ptr;
    w_run_nxt     = r_run;

    if (w_trig_ok_c) begin
      w_ptr_nxt = (r_ptr == LOG_CTX'(N_CONTEXT - 1)) ? '0 : r_ptr + LOG_CTX'(1);
    end
    if (w_finish) begin
      w_run_nxt = (r_run == LOG_CTX'(N_CONTEXT - 1)) ? '0 : r_run + LOG_CTX'(1);
    end

    case ({w_trig_ok_c, w_finish})
      2'b10:   w_pending_nxt = r_pending + PEND_W'(1);
      2'b01:   w_pending_nxt = r_pending - PEND_W'(1);
      default: w_pending_nxt = r_pending;
    endcase

    // A commit seen while idle starts the engine on the very next cycle
    case (r_state)
      IDLE:    if (w_pending_nxt != '0) w_state_nxt = START;
      START:   w_state_nxt = RUN;
      RUN:     if (done_i) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, ring registers and registered status outputs; clear aborts any job silently
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_ptr       <= '0;
      r_run       <= '0;
      r_start     <= 1'b0;
      r_true_done <= 1'b0;
      r_full      <= 1'b0;
      r_busy      <= 1'b0;
    end else if (clear_i) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_ptr       <= '0;
      r_run       <= '0;
      r_start     <= 1'b0;
      r_true_done <= 1'b0;
      r_full      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_ptr       <= w_ptr_nxt;
      r_run       <= w_run_nxt;
      r_start     <= (w_state_nxt == START);
      r_true_done <= (w_state_nxt == DONE);
      r_full      <= (w_pending_nxt == PEND_W'(N_CONTEXT));
      r_busy      <= (w_state_nxt != IDLE) || (w_pending_nxt != '0);
    end
  end

  assign w_flags = '{
    pointer_context: CTX_FLAG_IDX_W'(r_ptr),
    running_context: CTX_FLAG_IDX_W'(r_run),
    full_context:    r_full,
    is_critical:     w_lock,
    true_done:       r_true_done
  };

  assign start_o           = r_start;
  assign pointer_context_o = LOG_CTX'(w_flags.pointer_context);
  assign running_context_o = LOG_CTX'(w_flags.running_context);
  assign full_context_o    = w_flags.full_context;
  assign is_critical_o     = w_flags.is_critical;
  assign true_done_o       = w_flags.true_done;
  assign busy_o            = r_busy;
  assign lock_timeout_o    = w_lock_timeout;

endmodule
